// File: rtl/noc_axi4_bridge_pkg.sv
// noc_axi4_bridge_pkg: shared widths, FSM state type, flit field offsets and size-code decode
// for the NoC-to-AXI4 bridge write path.
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_STRB_WIDTH
`define AXI4_STRB_WIDTH 64
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif

package noc_axi4_bridge_pkg;
    localparam int AXI_DATA_W = `AXI4_DATA_WIDTH;
    localparam int AXI_STRB_W = `AXI4_STRB_WIDTH;
    localparam int AXI_ADDR_W = `AXI4_ADDR_WIDTH;
    localparam int AXI_ID_W   = `AXI4_ID_WIDTH;
    localparam int SIZE_LOG_W = `MSG_DATA_SIZE_WIDTH;

    localparam int LEN_LSB    = 22;
    localparam int LEN_W      = 8;
    localparam int MSHRID_LSB = 6;
    localparam int MSHRID_W   = 8;
    localparam int SRC_LSB    = 34;
    localparam int SRC_W      = 30;
    localparam int ADDR_LSB   = 0;
    localparam int ADDR_W     = 40;
    localparam int SIZE_LSB   = 52;
    localparam int SIZE_W     = 3;

    typedef enum logic [2:0] {HDR0, HDR1, HDR2, DATA, OUT} wr_state_e;

    // Header size code is log2(bytes)+1; code 0 is treated like code 1 (single byte).
    function automatic logic [SIZE_LOG_W-1:0] size_log_of(input logic [SIZE_W-1:0] code);
        return (code == '0) ? '0 : SIZE_LOG_W'(code - SIZE_W'(1));
    endfunction
endpackage

// File: rtl/noc_axi4_bridge_strb_gen.sv
// noc_axi4_bridge_strb_gen: byte strobe and first 64-bit data lane for a naturally
// aligned access of 2^size_log bytes within a 64-byte line.
module noc_axi4_bridge_strb_gen
    import noc_axi4_bridge_pkg::*;
(
    input  logic [5:0]            addr_i,
    input  logic [SIZE_LOG_W-1:0] size_log_i,
    output logic [AXI_STRB_W-1:0] strb_o,
    output logic [2:0]            base_lane_o
);
    logic [6:0]  nbytes;
    logic [5:0]  off;
    logic [2:0]  lanes_m1;
    logic [63:0] mask;

    always_comb begin
        nbytes      = 7'd1 << size_log_i;
        off         = addr_i & ~(nbytes[5:0] - 6'd1);
        mask        = {64{1'b1}} >> (7'd64 - nbytes);
        lanes_m1    = nbytes[5:3] - 3'd1;
        strb_o      = AXI_STRB_W'(mask << off);
        base_lane_o = (size_log_i >= SIZE_LOG_W'(3)) ? (addr_i[5:3] & ~lanes_m1) : addr_i[5:3];
    end
endmodule

// File: rtl/noc_axi4_bridge_wr_packer.sv
// noc_axi4_bridge_wr_packer: collects a NoC write-request message into one AXI4 write request.
// Optional payload-length check enabled by defining NOC_AXI4_WR_PACKER_LEN_CHECK_EN.
module noc_axi4_bridge_wr_packer
    import noc_axi4_bridge_pkg::*;
#(
    parameter int FLIT_WIDTH     = 64,
    parameter int MAX_DATA_FLITS = AXI_DATA_W / FLIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  noc_valid,
    input  logic [FLIT_WIDTH-1:0] noc_data,
    output logic                  noc_ready,
    output logic                  req_val,
    input  logic                  req_rdy,
    output logic [AXI_ADDR_W-1:0] req_addr,
    output logic [SIZE_LOG_W-1:0] req_size_log,
    output logic [AXI_ID_W-1:0]   req_id,
    output logic [AXI_DATA_W-1:0] req_data,
    output logic [AXI_STRB_W-1:0] req_strb,
    output logic [7:0]            req_mshrid,
    output logic [29:0]           req_src,
    output logic                  err_len
);
    wr_state_e             state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [7:0]            mshrid_q, mshrid_d;
    logic [29:0]           src_q, src_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [SIZE_LOG_W-1:0] size_q, size_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [AXI_DATA_W-1:0] data_q, data_d;
    logic [AXI_STRB_W-1:0] strb_q, strb_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [AXI_STRB_W-1:0] strb;
    logic [2:0]            base_lane;
    logic [8:0]            lane;

    noc_axi4_bridge_strb_gen u_strb_gen (
        .addr_i      (addr_q[5:0]),
        .size_log_i  (size_q),
        .strb_o      (strb),
        .base_lane_o (base_lane)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        mshrid_d = mshrid_q;
        src_d    = src_q;
        addr_d   = addr_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        strb_d   = strb_q;
        id_d     = id_q;
        lane     = 9'(base_lane) + 9'(cnt_q);
        case (state_q)
            HDR0: if (noc_valid) begin
                len_d    = noc_data[LEN_LSB +: LEN_W];
                mshrid_d = noc_data[MSHRID_LSB +: MSHRID_W];
                src_d    = noc_data[SRC_LSB +: SRC_W];
                data_d   = '0;
                strb_d   = '0;
                cnt_d    = '0;
                state_d  = HDR1;
            end
            HDR1: if (noc_valid) begin
                addr_d  = AXI_ADDR_W'(noc_data[ADDR_LSB +: ADDR_W]);
                size_d  = size_log_of(noc_data[SIZE_LSB +: SIZE_W]);
                state_d = HDR2;
            end
            HDR2: if (noc_valid) begin
                strb_d  = (len_q > LEN_W'(2)) ? strb : '0;
                state_d = (len_q > LEN_W'(2)) ? DATA : OUT;
            end
            DATA: if (noc_valid) begin
                // Lanes past the line are dropped rather than wrapped.
                if (int'(lane) < MAX_DATA_FLITS)
                    data_d[int'(lane)*FLIT_WIDTH +: FLIT_WIDTH] = noc_data;
                cnt_d   = cnt_q + LEN_W'(1);
                state_d = (cnt_q == len_q - LEN_W'(3)) ? OUT : DATA;
            end
            OUT: if (req_rdy) begin
                id_d    = id_q + AXI_ID_W'(1);
                state_d = HDR0;
            end
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HDR0;
            len_q    <= '0;
            mshrid_q <= '0;
            src_q    <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            mshrid_q <= mshrid_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            id_q     <= id_d;
        end
    end

    assign noc_ready    = (state_q != OUT);
    assign req_val      = (state_q == OUT);
    assign req_addr     = addr_q & ~AXI_ADDR_W'((7'd1 << size_q) - 7'd1);
    assign req_size_log = size_q;
    assign req_id       = id_q;
    assign req_data     = data_q;
    assign req_strb     = strb_q;
    assign req_mshrid   = mshrid_q;
    assign req_src      = src_q;

`ifdef NOC_AXI4_WR_PACKER_LEN_CHECK_EN
    logic                  err_q;
    logic [SIZE_LOG_W-1:0] hdr1_size;
    logic [8:0]            exp_len;

    // Expected L is two header flits plus one data flit per 64-bit lane (at least one).
    always_comb begin
        hdr1_size = size_log_of(noc_data[SIZE_LSB +: SIZE_W]);
        exp_len   = (hdr1_size >= SIZE_LOG_W'(3)) ? (9'd1 << (hdr1_size - SIZE_LOG_W'(3))) + 9'd2 : 9'd3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state_q == HDR1 && noc_valid && {1'b0, len_q} != exp_len)
            err_q <= 1'b1;
    end

    assign err_len = err_q;
`else
    assign err_len = 1'b0;
`endif
endmodule
